// File: rtl/hamming_pkg.sv
// Shared Hamming(7,4) codeword widths and types for the codeword path.
package hamming_pkg;

    localparam int CW_W  = 7;
    localparam int IDX_W = 3;
    localparam int CNT_W = 8;

    typedef logic [CW_W:1] codeword_t;

endpackage

// File: rtl/bit_flip_mask.sv
// Turns a bit index into a one-hot flip mask over codeword bits 1..CW_W;
// index 0 or anything past CW_W yields an all-zero mask.
module bit_flip_mask
    import hamming_pkg::*;
#(
    parameter int CW_W  = hamming_pkg::CW_W,
    parameter int IDX_W = hamming_pkg::IDX_W
) (
    input  logic [IDX_W-1:0] indx,
    output logic [CW_W:1]    mask
);

    always_comb begin
        mask = '0;
        for (int k = 1; k <= CW_W; k++) begin
            if (indx == IDX_W'(k)) mask[k] = 1'b1;
        end
    end

endmodule

// File: rtl/bit_corrupter.sv
// Registered single-bit error injector placed between Hamming encoder and
// decoder; also counts how many accepted words were corrupted.
module bit_corrupter
    import hamming_pkg::*;
#(
    parameter int CW_W  = hamming_pkg::CW_W,
    parameter int IDX_W = hamming_pkg::IDX_W,
    parameter int CNT_W = hamming_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [IDX_W-1:0] indx,
    input  logic [CW_W:1]    data_in,
    output logic             out_valid,
    output logic [CW_W:1]    data_out,
    output logic             corrupted,
    output logic [CNT_W-1:0] corrupt_cnt
);

    logic [CW_W:1] mask;
    logic          flip;

    bit_flip_mask #(.CW_W(CW_W), .IDX_W(IDX_W)) u_mask (
        .indx (indx),
        .mask (mask)
    );

    // Mask is one-hot or zero, so any set bit means exactly one flip.
    assign flip = |mask;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid   <= 1'b0;
            data_out    <= '0;
            corrupted   <= 1'b0;
            corrupt_cnt <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                data_out  <= data_in ^ mask;
                corrupted <= flip;
                if (flip) corrupt_cnt <= corrupt_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bit_corrupter.sv
// Directed table-driven bench for bit_corrupter plus reset/wrap sequences.
module tb_bit_corrupter;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [2:0] indx;
    logic [7:1] data_in;
    logic       out_valid;
    logic [7:1] data_out;
    logic       corrupted;
    logic [7:0] corrupt_cnt;

    int tests = 0;
    int fails = 0;

    bit_corrupter dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .indx        (indx),
        .data_in     (data_in),
        .out_valid   (out_valid),
        .data_out    (data_out),
        .corrupted   (corrupted),
        .corrupt_cnt (corrupt_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic [2:0] idx;
        logic [7:1] din;
        logic       ev;
        logic [7:1] edout;
        logic       ec;
        logic [7:0] ecnt;
    } vec_t;

    vec_t vecs[19];

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic ev, input logic [7:1] ed,
                           input logic ec, input logic [7:0] ecnt);
        chk({tag, ".out_valid"}, int'(out_valid), int'(ev));
        chk({tag, ".data_out"}, int'(data_out), int'(ed));
        chk({tag, ".corrupted"}, int'(corrupted), int'(ec));
        chk({tag, ".corrupt_cnt"}, int'(corrupt_cnt), int'(ecnt));
    endtask

    initial begin
        // zeros sweep
        vecs[0]  = '{1'b1, 3'd0, 7'b0000000, 1'b1, 7'b0000000, 1'b0, 8'd0};
        vecs[1]  = '{1'b1, 3'd1, 7'b0000000, 1'b1, 7'b0000001, 1'b1, 8'd1};
        vecs[2]  = '{1'b1, 3'd2, 7'b0000000, 1'b1, 7'b0000010, 1'b1, 8'd2};
        vecs[3]  = '{1'b1, 3'd3, 7'b0000000, 1'b1, 7'b0000100, 1'b1, 8'd3};
        vecs[4]  = '{1'b1, 3'd4, 7'b0000000, 1'b1, 7'b0001000, 1'b1, 8'd4};
        vecs[5]  = '{1'b1, 3'd5, 7'b0000000, 1'b1, 7'b0010000, 1'b1, 8'd5};
        vecs[6]  = '{1'b1, 3'd6, 7'b0000000, 1'b1, 7'b0100000, 1'b1, 8'd6};
        vecs[7]  = '{1'b1, 3'd7, 7'b0000000, 1'b1, 7'b1000000, 1'b1, 8'd7};
        // ones sweep
        vecs[8]  = '{1'b1, 3'd0, 7'b1111111, 1'b1, 7'b1111111, 1'b0, 8'd7};
        vecs[9]  = '{1'b1, 3'd1, 7'b1111111, 1'b1, 7'b1111110, 1'b1, 8'd8};
        vecs[10] = '{1'b1, 3'd2, 7'b1111111, 1'b1, 7'b1111101, 1'b1, 8'd9};
        vecs[11] = '{1'b1, 3'd3, 7'b1111111, 1'b1, 7'b1111011, 1'b1, 8'd10};
        vecs[12] = '{1'b1, 3'd4, 7'b1111111, 1'b1, 7'b1110111, 1'b1, 8'd11};
        vecs[13] = '{1'b1, 3'd5, 7'b1111111, 1'b1, 7'b1101111, 1'b1, 8'd12};
        vecs[14] = '{1'b1, 3'd6, 7'b1111111, 1'b1, 7'b1011111, 1'b1, 8'd13};
        vecs[15] = '{1'b1, 3'd7, 7'b1111111, 1'b1, 7'b0111111, 1'b1, 8'd14};
        // mixed pattern, then idle cycles must hold data_out/corrupted
        vecs[16] = '{1'b1, 3'd3, 7'b1010101, 1'b1, 7'b1010001, 1'b1, 8'd15};
        vecs[17] = '{1'b0, 3'd7, 7'b0000000, 1'b0, 7'b1010001, 1'b1, 8'd15};
        vecs[18] = '{1'b0, 3'd0, 7'b1111111, 1'b0, 7'b1010001, 1'b1, 8'd15};

        // reset held 2 cycles with valid input present
        rst = 1'b1; in_valid = 1'b1; indx = 3'd5; data_in = 7'b1111111;
        step();
        step();
        chk_all("reset", 1'b0, 7'b0, 1'b0, 8'd0);
        rst = 1'b0;

        for (int i = 0; i < 19; i++) begin
            in_valid = vecs[i].v;
            indx     = vecs[i].idx;
            data_in  = vecs[i].din;
            step();
            chk_all($sformatf("vec%0d", i), vecs[i].ev, vecs[i].edout, vecs[i].ec, vecs[i].ecnt);
        end

        // counter wrap after 256 corrupted words from reset
        rst = 1'b1; in_valid = 1'b0;
        step();
        chk("wrap.reset_cnt", int'(corrupt_cnt), 0);
        rst = 1'b0; in_valid = 1'b1; indx = 3'd1; data_in = 7'b0000000;
        for (int n = 1; n <= 256; n++) begin
            step();
            if (n == 1)   chk("wrap.cnt1", int'(corrupt_cnt), 1);
            if (n == 255) chk("wrap.cnt255", int'(corrupt_cnt), 255);
        end
        chk("wrap.cnt256", int'(corrupt_cnt), 0);
        chk("wrap.data", int'(data_out), 1);

        // one more corrupted word, then reset on the same edge as a valid word
        indx = 3'd5;
        step();
        chk_all("pre_rst", 1'b1, 7'b0010000, 1'b1, 8'd1);
        rst = 1'b1; in_valid = 1'b1; indx = 3'd5; data_in = 7'b1010101;
        step();
        chk_all("rst_drop", 1'b0, 7'b0, 1'b0, 8'd0);
        rst = 1'b0; in_valid = 1'b1; indx = 3'd0; data_in = 7'b1100110;
        step();
        chk_all("post_rst", 1'b1, 7'b1100110, 1'b0, 8'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
